// File: rtl/seven_seg_scanner_if.sv
// Bus between the result register side and the 7-segment scanner.
// The master drives the value/control inputs; the slave (the scanner) drives the display pins.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    load;
  logic                    lz_en;
  logic                    enable;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value, dp_mask, load, lz_en, enable,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_mask, load, lz_en, enable,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment driver with a pending/displayed value pair,
// leading-zero blanking, dead time and updates only at frame boundaries.
module seven_seg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int DEAD_CYCLES    = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seven_seg_scanner_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrap_q, wrap_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_end;
  logic                    xfer;
  logic [3:0]              cur_hex;
  logic                    cur_dp;
  logic                    zero_run;
  logic                    blank;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_on;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    wrap_d   = bus.enable && slot_end && (idx_q == IDX_LAST);
    cnt_d    = '0;
    idx_d    = '0;
    if (bus.enable) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      else          idx_d = idx_q;
    end

    // While scanning, transfer only at the wrap so a frame is never torn.
    xfer        = pend_flag_q && (!bus.enable || wrap_d);
    disp_val_d  = xfer ? pend_val_q : disp_val_q;
    disp_dp_d   = xfer ? pend_dp_q  : disp_dp_q;
    pend_val_d  = bus.load ? bus.value   : pend_val_q;
    pend_dp_d   = bus.load ? bus.dp_mask : pend_dp_q;
    pend_flag_d = bus.load ? 1'b1 : (xfer ? 1'b0 : pend_flag_q);
  end

  always_comb begin
    cur_hex  = 4'h0;
    cur_dp   = 1'b0;
    zero_run = 1'b1;
    blank    = 1'b0;
    an_on    = '0;
    // zero_run covers digits k..NUM_DIGITS-1 at iteration k.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_val_q[k*4 +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) begin
        cur_hex  = disp_val_q[k*4 +: 4];
        cur_dp   = disp_dp_q[k];
        blank    = bus.lz_en && (k != 0) && zero_run;
        an_on[k] = 1'b1;
      end
    end
    if (cnt_q < CNT_DEAD) an_on = '0;

    seg_raw      = blank ? 7'h00 : hex_to_seg(cur_hex);
    seg_d        = bus.enable ? (seg_raw ^ SEG_OFF) : SEG_OFF;
    dp_d         = bus.enable ? (cur_dp ^ DP_OFF)   : DP_OFF;
    an_d         = bus.enable ? (an_on ^ AN_OFF)    : AN_OFF;
    frame_done_d = bus.enable && wrap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4 digits, 4-cycle slots, 1 dead cycle, active-low pins.
module tb_seven_seg_scanner;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seven_seg_scanner_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (4),
    .DEAD_CYCLES   (1),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Disable, load a value, let the disabled-mode transfer happen, then start scanning.
  task automatic start_scan(input logic [15:0] v, input logic [3:0] m, input logic lz);
    @(negedge clk);
    bus.enable  = 1'b0;
    bus.value   = v;
    bus.dp_mask = m;
    bus.lz_en   = lz;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    bus.value   = '0;
    bus.dp_mask = '0;
    bus.load    = 1'b0;
    bus.lz_en   = 1'b0;
    bus.enable  = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.an !== 4'hF) begin fails++; $display("FAIL reset_an got=%h exp=%h", bus.an, 4'hF); end
    tests++;
    if (bus.seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got=%h exp=%h", bus.seg, 7'h7F); end
    tests++;
    if (bus.dp !== 1'b1) begin fails++; $display("FAIL reset_dp got=%b exp=1", bus.dp); end
    tests++;
    if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got=%b exp=0", bus.frame_done); end
    bus.enable = 1'b0;
    rst_n      = 1'b1;
  endtask

  task automatic test_scan;
    logic [6:0] es;
    logic [3:0] ea;
    start_scan(16'h12AF, 4'b0100, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      int c, d;
      @(negedge clk);
      c  = (k - 1) % 4;
      d  = ((k - 1) / 4) % 4;
      ea = (c == 0) ? 4'hF : ~(4'b0001 << d);
      case (d)
        0:       es = 7'h0E;
        1:       es = 7'h08;
        2:       es = 7'h24;
        default: es = 7'h79;
      endcase
      tests++;
      if (bus.an !== ea) begin fails++; $display("FAIL scan_an k=%0d got=%h exp=%h", k, bus.an, ea); end
      tests++;
      if (bus.seg !== es) begin fails++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, bus.seg, es); end
      tests++;
      if (bus.dp !== (d != 2)) begin fails++; $display("FAIL scan_dp k=%0d got=%b exp=%b", k, bus.dp, (d != 2)); end
      tests++;
      if (bus.frame_done !== (k == 17 || k == 33)) begin
        fails++; $display("FAIL scan_fd k=%0d got=%b exp=%b", k, bus.frame_done, (k == 17 || k == 33));
      end
    end
  endtask

  task automatic test_lz;
    logic [6:0] es;
    start_scan(16'h0005, 4'b1000, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      int d;
      @(negedge clk);
      d  = ((k - 1) / 4) % 4;
      es = (d == 0) ? 7'h12 : 7'h7F;
      tests++;
      if (bus.seg !== es) begin fails++; $display("FAIL lz5_seg k=%0d got=%h exp=%h", k, bus.seg, es); end
      tests++;
      if (bus.dp !== (d != 3)) begin fails++; $display("FAIL lz5_dp k=%0d got=%b exp=%b", k, bus.dp, (d != 3)); end
    end
    start_scan(16'h0005, 4'b0000, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      int d;
      @(negedge clk);
      d  = ((k - 1) / 4) % 4;
      es = (d == 0) ? 7'h12 : 7'h40;
      tests++;
      if (bus.seg !== es) begin fails++; $display("FAIL nolz_seg k=%0d got=%h exp=%h", k, bus.seg, es); end
    end
    start_scan(16'h0000, 4'b0000, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      int d;
      @(negedge clk);
      d  = ((k - 1) / 4) % 4;
      es = (d == 0) ? 7'h40 : 7'h7F;
      tests++;
      if (bus.seg !== es) begin fails++; $display("FAIL lz0_seg k=%0d got=%h exp=%h", k, bus.seg, es); end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] es;
    start_scan(16'h12AF, 4'b0000, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      int d;
      @(negedge clk);
      d = ((k - 1) / 4) % 4;
      if (k > 16)      es = 7'h24;
      else if (d == 0) es = 7'h0E;
      else if (d == 1) es = 7'h08;
      else if (d == 2) es = 7'h24;
      else             es = 7'h79;
      tests++;
      if (bus.seg !== es) begin fails++; $display("FAIL b2b_seg k=%0d got=%h exp=%h", k, bus.seg, es); end
      if (k == 6) begin bus.value = 16'h1111; bus.load = 1'b1; end
      if (k == 7) begin bus.value = 16'h2222; bus.load = 1'b1; end
      if (k == 8) bus.load = 1'b0;
    end
  endtask

  task automatic test_wrap_load;
    logic [6:0] es;
    start_scan(16'h12AF, 4'b0000, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      int d;
      @(negedge clk);
      d = ((k - 1) / 4) % 4;
      if (k > 32)      es = 7'h30;
      else if (d == 0) es = 7'h0E;
      else if (d == 1) es = 7'h08;
      else if (d == 2) es = 7'h24;
      else             es = 7'h79;
      tests++;
      if (bus.seg !== es) begin fails++; $display("FAIL wrapld_seg k=%0d got=%h exp=%h", k, bus.seg, es); end
      // Load held across the wrap edge (state cnt=3, idx=3).
      if (k == 15) begin bus.value = 16'h3333; bus.load = 1'b1; end
      if (k == 16) bus.load = 1'b0;
    end
  endtask

  task automatic test_disable;
    logic [3:0] ea;
    logic [6:0] es;
    start_scan(16'h12AF, 4'b0000, 1'b0);
    repeat (6) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.an !== 4'hF) begin fails++; $display("FAIL dis_an got=%h exp=%h", bus.an, 4'hF); end
    tests++;
    if (bus.seg !== 7'h7F) begin fails++; $display("FAIL dis_seg got=%h exp=%h", bus.seg, 7'h7F); end
    tests++;
    if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL dis_fd got=%b exp=0", bus.frame_done); end
    bus.value = 16'h0008;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ea = (k == 1 || k == 5) ? 4'hF : 4'hE;
      es = (k == 5) ? 7'h40 : 7'h00;
      tests++;
      if (bus.an !== ea) begin fails++; $display("FAIL resume_an k=%0d got=%h exp=%h", k, bus.an, ea); end
      tests++;
      if (bus.seg !== es) begin fails++; $display("FAIL resume_seg k=%0d got=%h exp=%h", k, bus.seg, es); end
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] ea;
    logic [6:0] es;
    start_scan(16'h12AF, 4'b1111, 1'b1);
    repeat (6) @(negedge clk);
    bus.value = 16'h0007;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.an !== 4'hF) begin fails++; $display("FAIL arst_an got=%h exp=%h", bus.an, 4'hF); end
    tests++;
    if (bus.seg !== 7'h7F) begin fails++; $display("FAIL arst_seg got=%h exp=%h", bus.seg, 7'h7F); end
    tests++;
    if (bus.dp !== 1'b1) begin fails++; $display("FAIL arst_dp got=%b exp=1", bus.dp); end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      int c, d;
      @(negedge clk);
      c  = (k - 1) % 4;
      d  = ((k - 1) / 4) % 4;
      ea = (c == 0) ? 4'hF : ~(4'b0001 << d);
      es = (d == 0) ? 7'h40 : 7'h7F;
      tests++;
      if (bus.an !== ea) begin fails++; $display("FAIL post_rst_an k=%0d got=%h exp=%h", k, bus.an, ea); end
      tests++;
      if (bus.seg !== es) begin fails++; $display("FAIL post_rst_seg k=%0d got=%h exp=%h", k, bus.seg, es); end
      tests++;
      if (bus.dp !== 1'b1) begin fails++; $display("FAIL post_rst_dp k=%0d got=%b exp=1", k, bus.dp); end
      tests++;
      if (bus.frame_done !== (k == 17)) begin
        fails++; $display("FAIL post_rst_fd k=%0d got=%b exp=%b", k, bus.frame_done, (k == 17));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_scan();
    test_lz();
    test_back_to_back();
    test_wrap_load();
    test_disable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
